// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIT stage sequencer for the 1-D FFT unit.
// Walks LOG_N stages of N = 2^LOG_N points. Each stage reads N operands
// (top/bottom per butterfly), then drains the butterfly pipeline for PIPE_LAT
// cycles. Write-back addresses are the read addresses delayed PIPE_LAT cycles.
// The operand banks ping-pong every stage: the read bank is stage[0] and the
// write bank is its complement.
//
// Handshake: i_start is sampled only in IDLE. o_busy is high from the first
// read cycle through the last drain cycle. o_done pulses for one cycle after
// the final write, with o_busy low. A new i_start is accepted from the cycle
// after o_done. i_abort is honoured only while o_busy is high; it returns the
// block to IDLE, flushes pending writes and suppresses o_done.
module fft_stage_sequencer #(
  parameter int LOG_N    = 10,
  parameter int PIPE_LAT = 4,
  parameter int STAGE_W  = 4
) (
  input  logic               i_fft_base_clock,
  input  logic               i_fft_reset_n,
  input  logic               i_start,
  input  logic               i_ifft,
  input  logic               i_abort,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_result_bank,
  output logic [STAGE_W-1:0] o_stage,
  output logic               o_rd_bank,
  output logic               o_rd_en,
  output logic [LOG_N-1:0]   o_rd_add,
  output logic               o_bf_start,
  output logic [LOG_N-2:0]   o_tw_add,
  output logic               o_tw_conj,
  output logic               o_wr_en,
  output logic [LOG_N-1:0]   o_wr_add,
  output logic [1:0]         o_fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [LOG_N-2:0]   J_LAST      = '1;
  localparam logic [3:0]         DRAIN_LAST  = 4'(PIPE_LAT - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST  = STAGE_W'(LOG_N - 1);
  localparam logic               RESULT_BANK = ((LOG_N % 2) == 1);

  state_t             state;
  state_t             state_nxt;
  logic [STAGE_W-1:0] stage;
  logic [LOG_N-2:0]   j;
  logic               phase;       // 0 = top operand, 1 = bottom operand
  logic [3:0]         drain_cnt;
  logic               tw_conj;
  logic               result_bank;

  logic               start_take;
  logic               abort_take;
  logic               last_bf;
  logic               drain_end;
  logic               last_stage;

  logic [LOG_N-1:0]   j_ext;
  logic [LOG_N-1:0]   span;
  logic [LOG_N-1:0]   low_mask;
  logic [LOG_N-1:0]   top_add;
  logic [LOG_N-1:0]   tw_full;
  logic [31:0]        tw_shift;

  logic               wr_en_sr  [PIPE_LAT];
  logic [LOG_N-1:0]   wr_add_sr [PIPE_LAT];

  // Control decodes shared by the FSM and the counters
  always_comb begin
    start_take = (state == IDLE) && i_start;
    abort_take = ((state == READ) || (state == DRAIN)) && i_abort;
    last_bf    = phase && (j == J_LAST);
    drain_end  = (drain_cnt == DRAIN_LAST);
    last_stage = (stage == STAGE_LAST);
  end

  // Butterfly address and twiddle index for butterfly j of the current stage.
  // The top-address shift is split so it never needs stage+1 in STAGE_W bits.
  always_comb begin
    j_ext    = LOG_N'(j);
    span     = LOG_N'(1) << stage;
    low_mask = span - LOG_N'(1);
    top_add  = (((j_ext >> stage) << 1) << stage) | (j_ext & low_mask);
    tw_shift = 32'(LOG_N - 1) - 32'(stage);
    tw_full  = (j_ext & low_mask) << tw_shift;
  end

  // FSM state register
  always_ff @(posedge i_fft_base_clock or negedge i_fft_reset_n) begin
    if (!i_fft_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and state-decoded outputs
  always_comb begin
    state_nxt  = state;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_rd_en    = 1'b0;
    o_rd_add   = '0;
    o_bf_start = 1'b0;
    o_tw_add   = '0;
    case (state)
      IDLE: begin
        if (start_take) state_nxt = READ;
      end
      READ: begin
        o_busy     = 1'b1;
        o_rd_en    = 1'b1;
        o_rd_add   = phase ? (top_add | span) : top_add;
        o_bf_start = !phase;
        o_tw_add   = phase ? '0 : tw_full[LOG_N-2:0];
        if (abort_take)   state_nxt = IDLE;
        else if (last_bf) state_nxt = DRAIN;
      end
      DRAIN: begin
        o_busy = 1'b1;
        if (abort_take)     state_nxt = IDLE;
        else if (drain_end) state_nxt = last_stage ? DONE : READ;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Butterfly/stage counters, drain timer and latched mode
  always_ff @(posedge i_fft_base_clock or negedge i_fft_reset_n) begin
    if (!i_fft_reset_n) begin
      stage       <= '0;
      j           <= '0;
      phase       <= 1'b0;
      drain_cnt   <= '0;
      tw_conj     <= 1'b0;
      result_bank <= 1'b0;
    end else if (start_take) begin
      stage       <= '0;
      j           <= '0;
      phase       <= 1'b0;
      drain_cnt   <= '0;
      tw_conj     <= i_ifft;
      result_bank <= 1'b0;
    end else if (!abort_take) begin
      if (state == READ) begin
        phase     <= !phase;
        drain_cnt <= '0;
        if (phase) j <= j + 1'b1;
      end else if (state == DRAIN) begin
        drain_cnt <= drain_cnt + 1'b1;
        if (drain_end) begin
          if (last_stage) begin
            result_bank <= RESULT_BANK;
          end else begin
            stage <= stage + 1'b1;
            j     <= '0;
            phase <= 1'b0;
          end
        end
      end
    end
  end

  // Write-back delay line; an abort empties it so no stale write escapes
  always_ff @(posedge i_fft_base_clock or negedge i_fft_reset_n) begin
    if (!i_fft_reset_n) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        wr_en_sr[i]  <= 1'b0;
        wr_add_sr[i] <= '0;
      end
    end else if (abort_take) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        wr_en_sr[i]  <= 1'b0;
        wr_add_sr[i] <= '0;
      end
    end else begin
      wr_en_sr[0]  <= o_rd_en;
      wr_add_sr[0] <= o_rd_add;
      for (int i = 1; i < PIPE_LAT; i++) begin
        wr_en_sr[i]  <= wr_en_sr[i-1];
        wr_add_sr[i] <= wr_add_sr[i-1];
      end
    end
  end

  // Register-driven outputs
  always_comb begin
    o_stage       = stage;
    o_rd_bank     = stage[0];
    o_tw_conj     = tw_conj;
    o_result_bank = result_bank;
    o_wr_en       = wr_en_sr[PIPE_LAT-1];
    o_wr_add      = wr_add_sr[PIPE_LAT-1];
    o_fsm_state   = state;
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer at LOG_N=3, PIPE_LAT=2.
// Cycle numbering: cycle 0 is the edge that samples i_start; outputs are
// observed 1 ns after each rising edge, so after k edges the visible values
// are those of cycle k.
module tb_fft_stage_sequencer;

  localparam int LOG_N    = 3;
  localparam int PIPE_LAT = 2;
  localparam int STAGE_W  = 4;
  localparam int N        = 8;
  localparam int PERIOD   = N + PIPE_LAT;           // 10
  localparam int T_DONE   = LOG_N * PERIOD + 1;     // 31

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               start = 1'b0;
  logic               ifft  = 1'b0;
  logic               abort = 1'b0;
  logic               busy, done, result_bank, rd_bank, rd_en, bf_start;
  logic               tw_conj, wr_en;
  logic [STAGE_W-1:0] stage;
  logic [LOG_N-1:0]   rd_add, wr_add;
  logic [LOG_N-2:0]   tw_add;
  logic [1:0]         fsm_state;

  fft_stage_sequencer #(
    .LOG_N(LOG_N), .PIPE_LAT(PIPE_LAT), .STAGE_W(STAGE_W)
  ) dut (
    .i_fft_base_clock(clk),
    .i_fft_reset_n   (rst_n),
    .i_start         (start),
    .i_ifft          (ifft),
    .i_abort         (abort),
    .o_busy          (busy),
    .o_done          (done),
    .o_result_bank   (result_bank),
    .o_stage         (stage),
    .o_rd_bank       (rd_bank),
    .o_rd_en         (rd_en),
    .o_rd_add        (rd_add),
    .o_bf_start      (bf_start),
    .o_tw_add        (tw_add),
    .o_tw_conj       (tw_conj),
    .o_wr_en         (wr_en),
    .o_wr_add        (wr_add),
    .o_fsm_state     (fsm_state)
  );

  // hand-computed read order and twiddles per stage
  int rd_tab [3][8] = '{'{0, 1, 2, 3, 4, 5, 6, 7},
                        '{0, 2, 1, 3, 4, 6, 5, 7},
                        '{0, 4, 1, 5, 2, 6, 3, 7}};
  int tw_tab [3][4] = '{'{0, 0, 0, 0},
                        '{0, 2, 0, 2},
                        '{0, 1, 2, 3}};

  // scoreboard
  logic [LOG_N-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int e_en, e_add, e_bf, e_tw;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // driver: advance one cycle and land 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // expected read-side activity for cycle c of a run started at cycle 0
  function automatic void exp_read(input int c, output int en, output int add,
                                   output int bf, output int tw);
    en = 0; add = 0; bf = 0; tw = 0;
    for (int s = 0; s < LOG_N; s++) begin
      int base;
      base = 1 + s * PERIOD;
      if (c >= base && c < base + N) begin
        en  = 1;
        add = rd_tab[s][c - base];
        bf  = ((c - base) % 2 == 0) ? 1 : 0;
        tw  = tw_tab[s][(c - base) / 2];
      end
    end
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_result_bank"}, result_bank, 0);
    check({tag, "_stage"}, stage, 0);
    check({tag, "_rd_bank"}, rd_bank, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_add"}, rd_add, 0);
    check({tag, "_bf_start"}, bf_start, 0);
    check({tag, "_tw_add"}, tw_add, 0);
    check({tag, "_tw_conj"}, tw_conj, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_add"}, wr_add, 0);
  endtask

  initial begin
    // reset state
    #3;
    check_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check("idle_busy", busy, 0);

    // full run: i_ifft dropped at cycle 2, i_start held high throughout
    exp_q.delete();
    start = 1'b1;
    ifft  = 1'b1;
    cyc   = 0;
    for (int k = 0; k < 33; k++) begin
      step();
      if (cyc == 2) ifft = 1'b0;
      if (cyc <= 30) begin
        exp_read(cyc, e_en, e_add, e_bf, e_tw);
        check("rd_en", rd_en, e_en);
        if (e_en != 0) begin
          check("rd_add", rd_add, e_add);
          exp_q.push_back(LOG_N'(e_add));
        end
        check("bf_start", bf_start, e_bf);
        if (e_bf != 0) check("tw_add", tw_add, e_tw);
        check("stage", stage, (cyc - 1) / PERIOD);
        check("rd_bank", rd_bank, ((cyc - 1) / PERIOD) % 2);
        check("busy", busy, 1);
        check("done_early", done, 0);
      end
      if (cyc <= 32) begin
        exp_read(cyc - PIPE_LAT, e_en, e_add, e_bf, e_tw);
        check("wr_en", wr_en, e_en);
      end
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
        else                   check("wr_add", wr_add, exp_q.pop_front());
      end
      if (cyc <= T_DONE) check("tw_conj", tw_conj, 1);
      if (cyc == T_DONE) begin
        check("done", done, 1);
        check("done_busy", busy, 0);
        check("done_rd_en", rd_en, 0);
        check("result_bank", result_bank, 1);
      end
      if (cyc == T_DONE + 1) begin
        check("post_done_busy", busy, 0);
        check("post_done_done", done, 0);
      end
      if (cyc == T_DONE + 2) begin
        // held i_start is taken once IDLE is reached again
        check("retrigger_busy", busy, 1);
        check("retrigger_stage", stage, 0);
        check("retrigger_rd_add", rd_add, 0);
        start = 1'b0;
        abort = 1'b1;
      end
    end
    step();
    abort = 1'b0;
    check("wr_queue_left", exp_q.size(), 0);
    check("abort1_busy", busy, 0);
    check("abort1_wr_en", wr_en, 0);

    // abort in stage 1, restart at cycle 16
    start = 1'b1;
    cyc   = 0;
    step();
    start = 1'b0;
    while (cyc < 14) begin
      step();
      if (cyc == 11) begin
        check("abort_s1_rd_add", rd_add, 0);
        check("abort_s1_stage", stage, 1);
        check("abort_s1_rd_bank", rd_bank, 1);
        check("abort_s1_wr_en", wr_en, 0);
      end
      if (cyc == 14) check("abort_pre_wr_en", wr_en, 1);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_rd_en", rd_en, 0);
    check("abort_wr_en", wr_en, 0);
    check("abort_done", done, 0);
    check("abort_state", fsm_state, 0);
    step();
    check("abort_idle_done", done, 0);
    check("abort_idle_wr_en", wr_en, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_busy", busy, 1);
    check("restart_stage", stage, 0);
    check("restart_rd_bank", rd_bank, 0);
    check("restart_rd_add", rd_add, 0);
    check("restart_bf_start", bf_start, 1);
    while (cyc < 16 + T_DONE) begin
      step();
      check("restart_done", done, (cyc == 16 + T_DONE) ? 1 : 0);
    end
    check("restart_result_bank", result_bank, 1);
    step();

    // asynchronous reset mid-transform
    start = 1'b1;
    ifft  = 1'b1;
    cyc   = 0;
    step();
    start = 1'b0;
    while (cyc < 5) step();
    check("pre_reset_busy", busy, 1);
    check("pre_reset_wr_en", wr_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      check("post_reset_wr_en", wr_en, 0);
      check("post_reset_busy", busy, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Parametrised radix-2 DIT stage sequencer replacing the fixed-size controller/AGU pair inside the 1-D FFT unit. For N = 2^LOG_N points it walks all LOG_N stages and issues butterfly operand read addresses, twiddle ROM addresses and delayed write-back addresses. Operands ping-pong between RAM bank 0 and RAM bank 1 each stage. It adds run-time FFT/IFFT selection, a configurable butterfly pipeline latency, abort, and a start/busy/done handshake.

## Interface
- LOG_N, default 10: log2 of the transform size; legal range 2..16.
- PIPE_LAT, default 4: cycles from a read address to the write address of the same element (RAM read plus butterfly); legal range 1..15.
- STAGE_W, default 4: width of the stage counter; must satisfy 2^STAGE_W >= LOG_N.
- i_fft_base_clock  in  1  sole clock; all logic on the rising edge.
- i_fft_reset_n  in  1  asynchronous, active-low reset.
- i_start  in  1  starts a transform when sampled high in IDLE.
- i_ifft  in  1  mode select, latched with i_start; 1 = inverse.
- i_abort  in  1  synchronous abort while busy.
- o_busy  out  1  high from the first read cycle until done.
- o_done  out  1  one-cycle pulse after the final write.
- o_result_bank  out  1  bank holding the result; valid from o_done until the next start.
- o_stage  out  STAGE_W  current stage s.
- o_rd_bank  out  1  bank being read (= s[0]); the write bank is ~o_rd_bank.
- o_rd_en  out  1  read address valid.
- o_rd_add  out  LOG_N  read address.
- o_bf_start  out  1  marks the top-operand read cycle.
- o_tw_add  out  LOG_N-1  twiddle ROM index, valid with o_bf_start.
- o_tw_conj  out  1  latched i_ifft; the butterfly conjugates the twiddle.
- o_wr_en  out  1  write address valid.
- o_wr_add  out  LOG_N  write address.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- **IDLE → READ:** on i_start. At the same edge: latch i_ifft, s = 0, j = 0, phase = top. i_start is ignored outside IDLE.
- **READ:** one operand per cycle, top then bottom, for butterfly j (0..N/2-1) of stage s.
  - span = 2^s.
  - top = ((j >> s) << (s+1)) | (j & (span-1)).
  - bottom = top | span.
  - tw = (j & (span-1)) << (LOG_N-1-s), truncated to LOG_N-1 bits.
  - o_bf_start and o_tw_add are asserted on the top cycle only.
  - After the bottom read of j = N/2-1, go to DRAIN.
- **DRAIN:** no reads; PIPE_LAT cycles. Then:
  - if s = LOG_N-1, go to DONE;
  - otherwise s++, j = 0, go to READ (o_rd_bank toggles).
- **DONE:** o_done = 1 for one cycle, o_busy = 0, then IDLE.
- **Write path:** o_wr_en and o_wr_add are o_rd_en and o_rd_add delayed exactly PIPE_LAT cycles through a shift register. The write bank never equals the read bank, so each stage writes in place at the addresses it read.
- o_result_bank = LOG_N[0].
- **Abort:** i_abort sampled high in READ or DRAIN has these effects at the next edge:
  - FSM goes to IDLE;
  - the delay pipeline is flushed, so o_wr_en = 0 immediately;
  - no o_done is generated.
  - i_abort is ignored in IDLE and DONE.
- **Reset:** asynchronous assertion at any time forces IDLE and sets every output and the pipeline to 0, including mid-transform. No pending writes are emitted after release.

## Timing
- Cycle 0 is the edge at which i_start is sampled.
- Stage s reads occupy cycles 1+s(N+PIPE_LAT) through N+s(N+PIPE_LAT); o_busy rises in cycle 1.
- The last write of stage s occurs in cycle (s+1)(N+PIPE_LAT). The next stage's first read follows in the next cycle; reads and writes never overlap across stages.
- o_done is high in cycle LOG_N(N+PIPE_LAT)+1, and o_busy is low in that same cycle.
- A new i_start is accepted in the cycle after o_done.
- The stage period is N+PIPE_LAT cycles. Total latency is LOG_N(N+PIPE_LAT)+1 cycles.
- Reset values of all outputs are 0.

## Test plan
- **Stage-0 addressing** (LOG_N=3, PIPE_LAT=2, i_start): cycles 1..8 give o_rd_add = 0,1,2,3,4,5,6,7; o_tw_add = 0 on every o_bf_start; o_rd_bank = 0.
- **Later stages, same config:**
  - stage 1 reads 0,2,1,3,4,6,5,7 with tw 0,2,0,2, starting at cycle 11;
  - stage 2 reads 0,4,1,5,2,6,3,7 with tw 0,1,2,3, starting at cycle 21, o_rd_bank = 0;
  - o_done at cycle 31, o_result_bank = 1.
- **Write path:** every o_wr_add equals the o_rd_add two cycles earlier; o_wr_en is never high while o_rd_en is high in a different stage.
- **Mode latch:** i_ifft = 1 with i_start, then i_ifft = 0 at cycle 2 → o_tw_conj stays 1 for the whole transform.
- **Abort:** i_abort at cycle 14 → cycle 15 in IDLE with o_busy = o_rd_en = o_wr_en = 0 and no o_done; i_start at cycle 16 restarts at stage 0.
- **Reset / ignored start:**
  - i_fft_reset_n low at cycle 5 → all outputs 0 asynchronously; no writes appear after release;
  - i_start held high throughout a run → not re-triggered until after o_done.
